rsa_stage_ctrl: RTL and testbench

//  Top-level EKF-SLAM stage controller for the systolic array (RSA) datapath.
//  - Accepts one-hot stage requests: predict, new-landmark, update.
//  - Launches the matching compute unit with an init pulse and waits for its done strobe.
//  - Commits the unit's results into the robot-state registers, a landmark table and the S_data register.

---
 rtl/rsa_pkg.sv | 21 ++
 rtl/rsa_lm_table.sv | 39 +++
 rtl/rsa_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_rsa_stage_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared stage codes, FSM state type and default widths for the RSA stage controller.
package rsa_pkg;

  localparam int RSA_DW_DEF     = 16;
  localparam int ROW_LEN_DEF    = 10;
  localparam int LM_DEPTH_DEF   = 16;
  localparam int SEQ_CNT_DW_DEF = 5;

  localparam logic [2:0] STAGE_IDLE = 3'b000;
  localparam logic [2:0] STAGE_PRD  = 3'b001;
  localparam logic [2:0] STAGE_NEW  = 3'b010;
  localparam logic [2:0] STAGE_UPD  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRD,
    ST_NEW,
    ST_UPD
  } rsa_state_t;

endpackage

// File: rtl/rsa_lm_table.sv
// Landmark table: DEPTH entries of (x, y), one synchronous write port, one async read port.
module rsa_lm_table #(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          sys_rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata_x,
  input  logic [DW-1:0] wdata_y,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata_x,
  output logic [DW-1:0] rdata_y
);

  logic [DW-1:0] lm_x_reg [DEPTH];
  logic [DW-1:0] lm_y_reg [DEPTH];

  // Every entry must clear on reset, so this is a register file rather than a RAM.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge sys_rst) begin
        if (!sys_rst) begin
          lm_x_reg[gi] <= '0;
          lm_y_reg[gi] <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          lm_x_reg[gi] <= wdata_x;
          lm_y_reg[gi] <= wdata_y;
        end
      end
    end
  endgenerate

  assign rdata_x = lm_x_reg[raddr];
  assign rdata_y = lm_y_reg[raddr];

endmodule

// File: rtl/rsa_stage_ctrl.sv
// EKF-SLAM stage controller: launches predict/new-landmark/update units and commits their results.
// Optional watchdog enabled by defining RSA_TIMEOUT_EN.
module rsa_stage_ctrl
  import rsa_pkg::*;
#(
  parameter int X          = 4,
  parameter int Y          = 4,
  parameter int L          = 4,
  parameter int RSA_DW     = RSA_DW_DEF,
  parameter int RSA_AW     = 17,
  parameter int TB_AW      = 11,
  parameter int CB_AW      = 17,
  parameter int SEQ_CNT_DW = SEQ_CNT_DW_DEF,
  parameter int ROW_LEN    = ROW_LEN_DEF,
  parameter int LM_DEPTH   = LM_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              sys_rst,
  input  logic [2:0]        stage_val,
  input  logic [ROW_LEN-1:0] landmark_num,
  input  logic [ROW_LEN-1:0] l_k,
  input  logic              done_predict,
  input  logic              done_newlm,
  input  logic              done_update,
  input  logic [RSA_DW-1:0] result_0,
  input  logic [RSA_DW-1:0] result_1,
  input  logic [RSA_DW-1:0] result_2,
  input  logic [RSA_DW-1:0] result_3,
  input  logic [RSA_DW-1:0] result_4,
  input  logic [RSA_DW-1:0] result_5,
  output logic [2:0]        stage_rdy,
  output logic [RSA_DW-1:0] S_data,
  output logic              init_predict,
  output logic              init_newlm,
  output logic              init_update,
  output logic [RSA_DW-1:0] xk,
  output logic [RSA_DW-1:0] yk,
  output logic [RSA_DW-1:0] xita,
  output logic [RSA_DW-1:0] lkx,
  output logic [RSA_DW-1:0] lky
);

  localparam int LM_AW = (LM_DEPTH > 1) ? $clog2(LM_DEPTH) : 1;

  rsa_state_t        state_reg, state_next;
  logic [2:0]        init_reg, init_next;
  logic [RSA_DW-1:0] xk_reg, xk_next, yk_reg, yk_next, xita_reg, xita_next;
  logic [RSA_DW-1:0] s_reg, s_next;
  logic              lm_we;
  logic [RSA_DW-1:0] lm_wx, lm_wy, lm_rx, lm_ry;
  logic              lm_hit, done_ok, timeout;
  logic [LM_AW-1:0]  lm_addr;

  assign lm_addr = l_k[LM_AW-1:0];
  assign lm_hit  = (l_k < landmark_num) && (32'(l_k) < LM_DEPTH);
  // The init cycle itself is not a completion window; done counts from the next cycle.
  assign done_ok = (init_reg == 3'b000);

`ifdef RSA_TIMEOUT_EN
  logic [SEQ_CNT_DW+2:0] wdog_reg;

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst)                wdog_reg <= '0;
    else if (state_reg == ST_IDLE) wdog_reg <= '0;
    else                         wdog_reg <= wdog_reg + 1'b1;
  end

  assign timeout = (wdog_reg == '1);
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_reg <= ST_IDLE;
      init_reg  <= 3'b000;
      xk_reg    <= '0;
      yk_reg    <= '0;
      xita_reg  <= '0;
      s_reg     <= '0;
    end else begin
      state_reg <= state_next;
      init_reg  <= init_next;
      xk_reg    <= xk_next;
      yk_reg    <= yk_next;
      xita_reg  <= xita_next;
      s_reg     <= s_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    init_next  = 3'b000;
    xk_next    = xk_reg;
    yk_next    = yk_reg;
    xita_next  = xita_reg;
    s_next     = s_reg;
    lm_we      = 1'b0;
    lm_wx      = lm_rx;
    lm_wy      = lm_ry;
    unique case (state_reg)
      ST_IDLE: begin
        init_next = stage_val;
        unique case (stage_val)
          STAGE_PRD: state_next = ST_PRD;
          STAGE_NEW: state_next = ST_NEW;
          STAGE_UPD: state_next = ST_UPD;
          default: begin
            state_next = ST_IDLE;
            init_next  = 3'b000;
          end
        endcase
      end
      ST_PRD: begin
        if (done_ok && done_predict) begin
          xk_next    = result_1;
          yk_next    = result_2;
          xita_next  = result_3;
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_NEW: begin
        if (done_ok && done_newlm) begin
          if (lm_hit) begin
            lm_we  = 1'b1;
            lm_wx  = result_0;
            lm_wy  = result_1;
            s_next = result_2;
          end
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      ST_UPD: begin
        if (done_ok && done_update) begin
          xk_next   = xk_reg + result_0;
          yk_next   = yk_reg + result_1;
          xita_next = xita_reg + result_2;
          lm_we     = lm_hit;
          lm_wx     = lm_rx + result_3;
          lm_wy     = lm_ry + result_4;
          s_next    = result_5;
          state_next = ST_IDLE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  rsa_lm_table #(
    .DW    (RSA_DW),
    .DEPTH (LM_DEPTH),
    .AW    (LM_AW)
  ) u_lm_table (
    .clk     (clk),
    .sys_rst (sys_rst),
    .we      (lm_we),
    .waddr   (lm_addr),
    .wdata_x (lm_wx),
    .wdata_y (lm_wy),
    .raddr   (lm_addr),
    .rdata_x (lm_rx),
    .rdata_y (lm_ry)
  );

  assign stage_rdy    = (state_reg == ST_IDLE) ? 3'b111 : 3'b000;
  assign init_predict = init_reg[0];
  assign init_newlm   = init_reg[1];
  assign init_update  = init_reg[2];
  assign xk           = xk_reg;
  assign yk           = yk_reg;
  assign xita         = xita_reg;
  assign S_data       = s_reg;
  assign lkx          = lm_hit ? lm_rx : '0;
  assign lky          = lm_hit ? lm_ry : '0;

endmodule

// File: tb/tb_rsa_stage_ctrl.sv
// Directed bench for rsa_stage_ctrl; covers the watchdog path when RSA_TIMEOUT_EN is defined.
module tb_rsa_stage_ctrl;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  stage_val;
  logic [9:0]  landmark_num, l_k;
  logic        done_predict, done_newlm, done_update;
  logic [15:0] result_0, result_1, result_2, result_3, result_4, result_5;
  logic [2:0]  stage_rdy;
  logic [15:0] S_data, xk, yk, xita, lkx, lky;
  logic        init_predict, init_newlm, init_update;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  rsa_stage_ctrl dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .stage_val    (stage_val),
    .landmark_num (landmark_num),
    .l_k          (l_k),
    .done_predict (done_predict),
    .done_newlm   (done_newlm),
    .done_update  (done_update),
    .result_0     (result_0),
    .result_1     (result_1),
    .result_2     (result_2),
    .result_3     (result_3),
    .result_4     (result_4),
    .result_5     (result_5),
    .stage_rdy    (stage_rdy),
    .S_data       (S_data),
    .init_predict (init_predict),
    .init_newlm   (init_newlm),
    .init_update  (init_update),
    .xk           (xk),
    .yk           (yk),
    .xita         (xita),
    .lkx          (lkx),
    .lky          (lky)
  );

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %-22s observed=%h expected=%h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_results(input logic [15:0] r0, r1, r2, r3, r4, r5);
    result_0 = r0; result_1 = r1; result_2 = r2;
    result_3 = r3; result_4 = r4; result_5 = r5;
  endtask

  initial begin
    sys_rst = 1'b0;
    stage_val = 3'b000; landmark_num = '0; l_k = '0;
    done_predict = 1'b0; done_newlm = 1'b0; done_update = 1'b0;
    set_results(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    step(2);
    chk("rst_stage_rdy", {13'b0, stage_rdy}, 16'h0007);
    chk("rst_xk", xk, 16'h0000);
    sys_rst = 1'b1;
    step();
    chk("idle_stage_rdy", {13'b0, stage_rdy}, 16'h0007);
    chk("idle_outputs", xk | yk | xita | S_data | lkx | lky, 16'h0000);

    // Not one-hot: must be rejected.
    stage_val = 3'b011;
    step();
    chk("bad_req_rdy", {13'b0, stage_rdy}, 16'h0007);
    chk("bad_req_init", {13'b0, init_update, init_newlm, init_predict}, 16'h0000);

    // PRD with the request held for two cycles.
    stage_val = 3'b001;
    step();
    chk("prd_init_pulse", {13'b0, init_update, init_newlm, init_predict}, 16'h0001);
    chk("prd_busy", {13'b0, stage_rdy}, 16'h0000);
    step();
    chk("prd_init_single", {15'b0, init_predict}, 16'h0000);
    stage_val = 3'b000;
    step();
    // Wrong done in PRD: ignored.
    set_results(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066);
    done_update = 1'b1;
    step();
    done_update = 1'b0;
    chk("wrong_done_busy", {13'b0, stage_rdy}, 16'h0000);
    chk("wrong_done_xk", xk, 16'h0000);
    chk("wrong_done_S", S_data, 16'h0000);
    set_results(16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0000, 16'h0000);
    done_predict = 1'b1;
    step();
    done_predict = 1'b0;
    chk("prd_xk", xk, 16'h0001);
    chk("prd_yk", yk, 16'h0002);
    chk("prd_xita", xita, 16'h0003);
    chk("prd_rdy", {13'b0, stage_rdy}, 16'h0007);

    // NEW landmark at index 2.
    l_k = 10'd2; landmark_num = 10'd4;
    stage_val = 3'b010;
    step();
    stage_val = 3'b000;
    chk("new_init_pulse", {13'b0, init_update, init_newlm, init_predict}, 16'h0002);
    step();
    set_results(16'hFFFF, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000);
    done_newlm = 1'b1;
    step();
    done_newlm = 1'b0;
    chk("new_lkx", lkx, 16'hFFFF);
    chk("new_lky", lky, 16'h0001);
    chk("new_S", S_data, 16'h0002);

    // UPD accumulates onto the pose (1,2,3) and the entry (FFFF,1).
    stage_val = 3'b100;
    step();
    stage_val = 3'b000;
    chk("upd_init_pulse", {13'b0, init_update, init_newlm, init_predict}, 16'h0004);
    step();
    set_results(16'hFFFF, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005);
    done_update = 1'b1;
    step();
    done_update = 1'b0;
    chk("upd_xk_wrap", xk, 16'h0000);
    chk("upd_yk", yk, 16'h0003);
    chk("upd_xita", xita, 16'h0005);
    chk("upd_lkx", lkx, 16'h0002);
    chk("upd_lky", lky, 16'h0005);
    chk("upd_S", S_data, 16'h0005);

    // Out-of-range index: reads 0 and a NEW commits nothing.
    l_k = 10'd4;
    #1;
    chk("oor_read", lkx | lky, 16'h0000);
    stage_val = 3'b010;
    step();
    stage_val = 3'b000;
    step();
    set_results(16'h0007, 16'h0008, 16'h0009, 16'h0000, 16'h0000, 16'h0000);
    done_newlm = 1'b1;
    step();
    done_newlm = 1'b0;
    chk("oor_S_kept", S_data, 16'h0005);
    landmark_num = 10'd5;
    #1;
    chk("oor_no_write", lkx | lky, 16'h0000);
    l_k = 10'd2;
    #1;
    chk("oor_entry2_kept", lkx, 16'h0002);

`ifdef RSA_TIMEOUT_EN
    // Watchdog: PRD with no done returns to IDLE untouched.
    stage_val = 3'b001;
    step();
    stage_val = 3'b000;
    step(250);
    chk("wdog_still_busy", {13'b0, stage_rdy}, 16'h0000);
    step(10);
    chk("wdog_idle", {13'b0, stage_rdy}, 16'h0007);
    chk("wdog_xk_kept", xk, 16'h0000);
    chk("wdog_yk_kept", yk, 16'h0003);
`else
    // Without the watchdog the stage waits indefinitely.
    stage_val = 3'b001;
    step();
    stage_val = 3'b000;
    step(300);
    chk("nowdog_busy", {13'b0, stage_rdy}, 16'h0000);
    set_results(16'h0000, 16'h000A, 16'h000B, 16'h000C, 16'h0000, 16'h0000);
    done_predict = 1'b1;
    step();
    done_predict = 1'b0;
    chk("late_prd_xk", xk, 16'h000A);
`endif

    // Reset in the middle of an update aborts and clears everything.
    stage_val = 3'b100;
    step();
    stage_val = 3'b000;
    step();
    sys_rst = 1'b0;
    #1;
    chk("midrst_rdy", {13'b0, stage_rdy}, 16'h0007);
    chk("midrst_regs", xk | yk | xita | S_data, 16'h0000);
    chk("midrst_init", {13'b0, init_update, init_newlm, init_predict}, 16'h0000);
    step();
    sys_rst = 1'b1;
    landmark_num = 10'd4;
    step();
    chk("midrst_table", lkx | lky, 16'h0000);
    chk("midrst_idle", {13'b0, stage_rdy}, 16'h0007);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
